// File: rtl/tinycpu_io_bridge.sv
// tinycpu_io_bridge
//   Connects a host to the tiny CPU's `in`/`out` ports using two independent
//   first-word-fall-through FIFOs.
//   Input path  : host_in_data/valid/ready  -> FIFO -> cpu_in/cpu_in_valid/cpu_in_ack
//   Output path : cpu_out/cpu_out_we/cpu_out_full -> FIFO -> host_out_data/valid/ready
//   Status      : ovf (sticky dropped-write flag), in_count, out_count (0..DEPTH)
//   clk rising edge; reset is asynchronous and active-low.
//   Every output is derived from registered state only.
module tinycpu_io_bridge #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         host_in_data,
   input  logic                     host_in_valid,
   output logic                     host_in_ready,
   output logic [WIDTH-1:0]         cpu_in,
   output logic                     cpu_in_valid,
   input  logic                     cpu_in_ack,
   input  logic [WIDTH-1:0]         cpu_out,
   input  logic                     cpu_out_we,
   output logic                     cpu_out_full,
   output logic [WIDTH-1:0]         host_out_data,
   output logic                     host_out_valid,
   input  logic                     host_out_ready,
   output logic                     ovf,
   output logic [$clog2(DEPTH):0]   in_count,
   output logic [$clog2(DEPTH):0]   out_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // Input FIFO state
   logic [WIDTH-1:0] in_mem_q [DEPTH];
   logic [AW-1:0]    in_rd_q, in_wr_q;
   logic [CW-1:0]    in_cnt_q, in_cnt_d;
   logic             in_rdy_q;
   logic             in_push, in_pop;

   // Output FIFO state
   logic [WIDTH-1:0] out_mem_q [DEPTH];
   logic [AW-1:0]    out_rd_q, out_wr_q;
   logic [CW-1:0]    out_cnt_q, out_cnt_d;
   logic             out_push, out_pop, out_drop, out_is_full;
   logic             ovf_q;

   // Handshake decode
   always_comb begin
      in_push     = host_in_valid & in_rdy_q;
      in_pop      = cpu_in_ack & (in_cnt_q != '0);
      in_cnt_d    = in_cnt_q + CW'(in_push) - CW'(in_pop);

      out_is_full = (out_cnt_q == FULL);
      out_pop     = host_out_ready & (out_cnt_q != '0);
      // A full FIFO still accepts a write when the host frees a slot the same cycle.
      out_push    = cpu_out_we & (~out_is_full | out_pop);
      out_drop    = cpu_out_we & out_is_full & ~out_pop;
      out_cnt_d   = out_cnt_q + CW'(out_push) - CW'(out_pop);
   end

   // Pointers, counts and flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_rd_q   <= '0;
         in_wr_q   <= '0;
         in_cnt_q  <= '0;
         in_rdy_q  <= 1'b0;
         out_rd_q  <= '0;
         out_wr_q  <= '0;
         out_cnt_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         // Power-of-two depth: pointers wrap naturally.
         if (in_push)  in_wr_q  <= in_wr_q + 1'b1;
         if (in_pop)   in_rd_q  <= in_rd_q + 1'b1;
         in_cnt_q <= in_cnt_d;
         // Registered ready keeps it low in reset and free of input paths.
         in_rdy_q <= (in_cnt_d != FULL);

         if (out_push) out_wr_q <= out_wr_q + 1'b1;
         if (out_pop)  out_rd_q <= out_rd_q + 1'b1;
         out_cnt_q <= out_cnt_d;
         if (out_drop) ovf_q <= 1'b1;
      end
   end

   // Storage needs no reset; empty counts mask stale contents.
   always_ff @(posedge clk) begin
      if (in_push)  in_mem_q[in_wr_q]   <= host_in_data;
      if (out_push) out_mem_q[out_wr_q] <= cpu_out;
   end

   // Outputs
   always_comb begin
      host_in_ready  = in_rdy_q;
      cpu_in_valid   = (in_cnt_q != '0);
      cpu_in         = cpu_in_valid ? in_mem_q[in_rd_q] : '0;
      in_count       = in_cnt_q;

      cpu_out_full   = out_is_full;
      host_out_valid = (out_cnt_q != '0);
      host_out_data  = host_out_valid ? out_mem_q[out_rd_q] : '0;
      out_count      = out_cnt_q;
      ovf            = ovf_q;
   end

endmodule

// File: tb/tb_tinycpu_io_bridge.sv
// Self-checking bench for tinycpu_io_bridge: queue-based reference model
// compared on every falling edge, plus directed scenarios with literal values.
module tb_tinycpu_io_bridge;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [WIDTH-1:0]  host_in_data = '0;
   logic              host_in_valid = 1'b0;
   logic              host_in_ready;
   logic [WIDTH-1:0]  cpu_in;
   logic              cpu_in_valid;
   logic              cpu_in_ack = 1'b0;
   logic [WIDTH-1:0]  cpu_out = '0;
   logic              cpu_out_we = 1'b0;
   logic              cpu_out_full;
   logic [WIDTH-1:0]  host_out_data;
   logic              host_out_valid;
   logic              host_out_ready = 1'b0;
   logic              ovf;
   logic [2:0]        in_count, out_count;

   int checks = 0;
   int failures = 0;

   tinycpu_io_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .host_in_data   (host_in_data),
      .host_in_valid  (host_in_valid),
      .host_in_ready  (host_in_ready),
      .cpu_in         (cpu_in),
      .cpu_in_valid   (cpu_in_valid),
      .cpu_in_ack     (cpu_in_ack),
      .cpu_out        (cpu_out),
      .cpu_out_we     (cpu_out_we),
      .cpu_out_full   (cpu_out_full),
      .host_out_data  (host_out_data),
      .host_out_valid (host_out_valid),
      .host_out_ready (host_out_ready),
      .ovf            (ovf),
      .in_count       (in_count),
      .out_count      (out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [WIDTH-1:0] mq_in[$];
   logic [WIDTH-1:0] mq_out[$];
   bit m_in_rdy = 1'b0;
   bit m_ovf = 1'b0;
   bit m_ipush, m_ipop, m_opop, m_ofull;

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         mq_in.delete();
         mq_out.delete();
         m_in_rdy = 1'b0;
         m_ovf = 1'b0;
      end else begin
         m_ipush = host_in_valid && m_in_rdy;
         m_ipop  = cpu_in_ack && (mq_in.size() != 0);
         if (m_ipop)  void'(mq_in.pop_front());
         if (m_ipush) mq_in.push_back(host_in_data);
         m_in_rdy = (mq_in.size() != DEPTH);

         m_opop  = host_out_ready && (mq_out.size() != 0);
         m_ofull = (mq_out.size() == DEPTH);
         if (m_opop) void'(mq_out.pop_front());
         if (cpu_out_we) begin
            if (!m_ofull || m_opop) mq_out.push_back(cpu_out);
            else m_ovf = 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("host_in_ready", 32'(host_in_ready), 32'(m_in_rdy));
      chk("cpu_in_valid", 32'(cpu_in_valid), 32'(mq_in.size() != 0));
      chk("cpu_in", 32'(cpu_in), (mq_in.size() != 0) ? 32'(mq_in[0]) : 32'h0);
      chk("in_count", 32'(in_count), 32'(mq_in.size()));
      chk("cpu_out_full", 32'(cpu_out_full), 32'(mq_out.size() == DEPTH));
      chk("host_out_valid", 32'(host_out_valid), 32'(mq_out.size() != 0));
      chk("host_out_data", 32'(host_out_data), (mq_out.size() != 0) ? 32'(mq_out[0]) : 32'h0);
      chk("out_count", 32'(out_count), 32'(mq_out.size()));
      chk("ovf", 32'(ovf), 32'(m_ovf));
   end

   // Stimulus changes 2 time units after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rdy"}, 32'(host_in_ready), 32'h0);
      chk({tag, "_cpu_in"}, 32'(cpu_in), 32'h0);
      chk({tag, "_cpu_in_valid"}, 32'(cpu_in_valid), 32'h0);
      chk({tag, "_full"}, 32'(cpu_out_full), 32'h0);
      chk({tag, "_hov"}, 32'(host_out_valid), 32'h0);
      chk({tag, "_hod"}, 32'(host_out_data), 32'h0);
      chk({tag, "_ovf"}, 32'(ovf), 32'h0);
      chk({tag, "_inc"}, 32'(in_count), 32'h0);
      chk({tag, "_outc"}, 32'(out_count), 32'h0);
   endtask

   logic [WIDTH-1:0] rx_in[$];
   logic [WIDTH-1:0] rx_out[$];
   int hi, oi;
   bit acc_h;

   initial begin
      #1;
      // Reset state
      step();
      chk_reset_outputs("rst");
      step();
      reset = 1'b1;
      step();
      chk("rdy_after_rst", 32'(host_in_ready), 32'h1);

      // Two words, fall-through and ack
      host_in_valid = 1'b1; host_in_data = 16'd3;
      step();
      host_in_data = 16'd5;
      step();
      host_in_valid = 1'b0;
      chk("t1_cpu_in", 32'(cpu_in), 32'd3);
      chk("t1_valid", 32'(cpu_in_valid), 32'h1);
      chk("t1_cnt", 32'(in_count), 32'd2);
      cpu_in_ack = 1'b1;
      step();
      chk("t1_cpu_in2", 32'(cpu_in), 32'd5);
      step();
      cpu_in_ack = 1'b0;
      chk("t1_empty_valid", 32'(cpu_in_valid), 32'h0);
      chk("t1_empty_data", 32'(cpu_in), 32'h0);

      // Fill input FIFO, fifth word waits for the cycle after the first ack
      host_in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         host_in_data = 16'(i);
         step();
      end
      chk("t2_rdy_full", 32'(host_in_ready), 32'h0);
      chk("t2_cnt_full", 32'(in_count), 32'd4);
      host_in_data = 16'd5;
      step();
      chk("t2_held_cnt", 32'(in_count), 32'd4);
      cpu_in_ack = 1'b1;
      step();
      cpu_in_ack = 1'b0;
      chk("t2_after_ack_cnt", 32'(in_count), 32'd3);
      chk("t2_after_ack_rdy", 32'(host_in_ready), 32'h1);
      step();
      host_in_valid = 1'b0;
      chk("t2_accept_cnt", 32'(in_count), 32'd4);
      cpu_in_ack = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         chk("t2_drain", 32'(cpu_in), 32'(i));
         step();
      end
      cpu_in_ack = 1'b0;
      chk("t2_drained", 32'(in_count), 32'd0);

      // Overflow drops the fifth write
      cpu_out_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cpu_out = 16'hAAAA + 16'(i);
         step();
      end
      chk("t3_full", 32'(cpu_out_full), 32'h1);
      chk("t3_ovf0", 32'(ovf), 32'h0);
      cpu_out = 16'hBEEF;
      step();
      cpu_out_we = 1'b0;
      chk("t3_ovf1", 32'(ovf), 32'h1);
      chk("t3_cnt", 32'(out_count), 32'd4);
      host_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t3_drain", 32'(host_out_data), 32'hAAAA + 32'(i));
         step();
      end
      host_out_ready = 1'b0;
      chk("t3_empty_valid", 32'(host_out_valid), 32'h0);
      chk("t3_empty_data", 32'(host_out_data), 32'h0);
      chk("t3_ovf_sticky", 32'(ovf), 32'h1);

      // Reset mid-transfer with both FIFOs at 2 and ovf set
      host_in_valid = 1'b1; cpu_out_we = 1'b1;
      for (int i = 0; i < 2; i++) begin
         host_in_data = 16'h0C00 + 16'(i);
         cpu_out = 16'h0D00 + 16'(i);
         step();
      end
      host_in_valid = 1'b0; cpu_out_we = 1'b0;
      chk("t5_pre_inc", 32'(in_count), 32'd2);
      chk("t5_pre_outc", 32'(out_count), 32'd2);
      chk("t5_pre_ovf", 32'(ovf), 32'h1);
      reset = 1'b0;
      #1;
      chk_reset_outputs("t5_async");
      step();
      reset = 1'b1;
      step();
      chk("t5_rdy", 32'(host_in_ready), 32'h1);
      chk("t5_inc", 32'(in_count), 32'd0);
      chk("t5_outc", 32'(out_count), 32'd0);

      // Write into a full output FIFO while the host pops
      cpu_out_we = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cpu_out = 16'(i);
         step();
      end
      cpu_out = 16'h1234;
      host_out_ready = 1'b1;
      step();
      cpu_out_we = 1'b0;
      host_out_ready = 1'b0;
      chk("t4_cnt", 32'(out_count), 32'd4);
      chk("t4_ovf", 32'(ovf), 32'h0);
      host_out_ready = 1'b1;
      chk("t4_d0", 32'(host_out_data), 32'd2); step();
      chk("t4_d1", 32'(host_out_data), 32'd3); step();
      chk("t4_d2", 32'(host_out_data), 32'd4); step();
      chk("t4_d3", 32'(host_out_data), 32'h1234); step();
      host_out_ready = 1'b0;
      chk("t4_empty", 32'(out_count), 32'd0);

      // Random handshakes, ten words through each FIFO
      hi = 0; oi = 0;
      for (int cyc = 0; cyc < 600 && (rx_in.size() < 10 || rx_out.size() < 10); cyc++) begin
         host_in_valid  = (hi < 10) && ($urandom_range(0, 1) == 1);
         host_in_data   = 16'h0100 + 16'(hi);
         cpu_in_ack     = ($urandom_range(0, 2) != 0);
         cpu_out_we     = (oi < 10) && !cpu_out_full && ($urandom_range(0, 1) == 1);
         cpu_out        = 16'h0200 + 16'(oi);
         host_out_ready = ($urandom_range(0, 2) != 0);
         acc_h = host_in_valid && host_in_ready;
         if (cpu_in_ack && cpu_in_valid) rx_in.push_back(cpu_in);
         if (host_out_ready && host_out_valid) rx_out.push_back(host_out_data);
         step();
         if (acc_h) hi++;
         if (cpu_out_we) oi++;
      end
      host_in_valid = 1'b0; cpu_in_ack = 1'b0; cpu_out_we = 1'b0; host_out_ready = 1'b0;
      chk("t6_in_n", 32'(rx_in.size()), 32'd10);
      chk("t6_out_n", 32'(rx_out.size()), 32'd10);
      for (int i = 0; i < rx_in.size(); i++)
         chk("t6_in_word", 32'(rx_in[i]), 32'h0100 + 32'(i));
      for (int i = 0; i < rx_out.size(); i++)
         chk("t6_out_word", 32'(rx_out[i]), 32'h0200 + 32'(i));
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
